// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
// Ports: clk, rst_n (sync, active-low), start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH:0]   r_prem;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_dz;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH:0]   w_prem_nx;
  logic             w_unused;

  assign w_accept = start && (r_state != S_RUN);
  assign w_dz     = (divisor == '0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Partial remainder stays below the divisor, so its top bit
  // is always 0 and drops out of the shift.
  assign w_shift   = {r_prem[WIDTH-1:0], r_sreg[WIDTH-1]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_borrow  = w_diff[WIDTH+1];
  assign w_prem_nx = w_borrow ? w_shift : w_diff[WIDTH:0];
  assign w_unused  = r_prem[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_dz ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (w_accept) w_next = w_dz ? S_DONE : S_RUN;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_sreg holds the unconsumed dividend bits in its upper part
  // and collects quotient bits at the bottom.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prem <= '0;
      r_sreg <= '0;
      r_dvs  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_prem <= '0;
      r_cnt  <= '0;
      r_sreg <= dividend;
      r_dvs  <= divisor;
      if (w_dz) begin
        r_quot <= '1;
        r_rem  <= dividend;
        r_dbz  <= 1'b1;
      end else begin
        r_quot <= '0;
        r_rem  <= '0;
        r_dbz  <= 1'b0;
      end
    end else if (r_state == S_RUN) begin
      r_prem <= w_prem_nx;
      r_sreg <= {r_sreg[WIDTH-2:0], ~w_borrow};
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        r_quot <= {r_sreg[WIDTH-2:0], ~w_borrow};
        r_rem  <= w_prem_nx[WIDTH-1:0];
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule
